jtcps1_vram_arb: RTL
====================

JTCPS1_VRAM_ARB -- requirements
Module: jtcps1_vram_arb

Interface
REQ-001 SHALL have parameter ASN_WAIT, default 2: consecutive clk cycles cpu_asn must be high, with cpu_bgn low, before ownership is taken.
REQ-002 SHALL have clk, input, 1: system clock; the block uses this one clock only.
REQ-003 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have busreq (in, 1) and busack (out, 1): the video-side bus request and grant.
REQ-005 SHALL have vram_dma_addr (in, 17, [17:1]), vram_dma_cs (in, 1) and vram_dma_clr (in, 1): the video-side read address, read strobe and abort.
REQ-006 SHALL have vram_dma_data (out, 16) and vram_dma_ok (out, 1): the video-side read data and data-valid.
REQ-007 SHALL have the 68000-side signals cpu_asn (in, 1, address strobe, active low), cpu_brn (out, 1, bus request, active low), cpu_bgn (in, 1, bus grant, active low) and cpu_bgackn (out, 1, grant acknowledge, active low).
REQ-008 SHALL have the SDRAM-side signals sdram_addr (out, 17, [17:1]), sdram_cs (out, 1), sdram_data (in, 16) and sdram_ok (in, 1).

Function
REQ-009 SHALL implement the states IDLE, REQ, WAITAS, OWN and DRAIN, encoded in 3 bits.
REQ-010 IDLE: on busreq=1, SHALL go to REQ and drive cpu_brn=0 from the next cycle.
REQ-011 REQ: SHALL move to WAITAS when cpu_bgn=0.
REQ-012 WAITAS: SHALL count consecutive cycles with cpu_asn=1; the count SHALL restart when cpu_asn=0.
REQ-013 WAITAS: when the count reaches ASN_WAIT, SHALL go to OWN, drive cpu_bgackn=0 and busack=1 in the same cycle, and release cpu_brn to 1.
REQ-014 OWN: on vram_dma_cs=1 with no valid data for the current vram_dma_addr, SHALL drive sdram_cs=1 and sdram_addr=vram_dma_addr.
REQ-015 OWN: on sdram_ok=1, SHALL latch sdram_data, mark it valid for that address and drop sdram_cs.
REQ-016 OWN: vram_dma_ok SHALL be 1 only while vram_dma_cs=1 and vram_dma_addr equals the latched valid address; vram_dma_ok SHALL fall in the same cycle the address changes.
REQ-017 The read latency from the address to vram_dma_ok SHALL be 1 clk after the sdram_ok cycle.
REQ-018 vram_dma_clr=1 SHALL clear the valid flag and drop sdram_cs on the next cycle.
REQ-019 An sdram_ok that arrives for a cleared (aborted) request SHALL be ignored.
REQ-020 vram_dma_clr SHALL take priority over a simultaneous sdram_ok.
REQ-021 OWN with busreq=0: if no SDRAM read is pending, SHALL go to IDLE; otherwise SHALL go to DRAIN.
REQ-022 DRAIN: SHALL keep busack=1 until sdram_ok arrives, discard that data, then go to IDLE.
REQ-023 On entering IDLE, SHALL set busack=0 and cpu_bgackn=1 in the same cycle.
REQ-024 If busreq falls while in REQ or WAITAS, SHALL release cpu_brn and return to IDLE without asserting busack.
REQ-025 Outside OWN and DRAIN, sdram_cs SHALL stay 0 and vram_dma_cs SHALL be ignored.
REQ-026 The ASN_WAIT counter SHALL saturate at ASN_WAIT and never wrap.

Reset
REQ-027 While rst=1, SHALL hold state IDLE and outputs cpu_brn=1, cpu_bgackn=1, busack=0, sdram_cs=0, vram_dma_ok=0, sdram_addr=0 and vram_dma_data=0, and SHALL clear the valid flag.
REQ-028 A reset asserted in OWN or DRAIN SHALL abandon any pending read, and a late sdram_ok after reset SHALL be ignored.

Configuration
REQ-029 With JTCPS1_VRAMCACHE_EN defined, SHALL add a 4-entry direct-mapped cache, indexed by addr[2:1], that hits with vram_dma_ok one cycle after cs without any SDRAM access.
REQ-030 With JTCPS1_VRAMCACHE_EN defined, vram_dma_clr and exit from OWN SHALL invalidate all cache entries.
REQ-031 Without JTCPS1_VRAMCACHE_EN, SHALL keep only the single latched word of REQ-015 to REQ-016.

Structure
REQ-032 The state encodings and the ASN_WAIT default SHALL be defined in the shared package jtcps1_pkg.
REQ-033 The cache SHALL be one sub-module, jtcps1_vram_cache, instantiated only when JTCPS1_VRAMCACHE_EN is defined.

Verification
REQ-034 Grant sequence: busreq=1, cpu_bgn=0 at cycle 3, cpu_asn=1 held -> busack=1 and cpu_bgackn=0 exactly 2 cycles later, with cpu_brn=1.
REQ-035 Read: in OWN, addr=17'h0400 with cs=1, sdram_ok at cycle 5 carrying data 16'hBEEF -> vram_dma_ok=1 at cycle 6 with vram_dma_data=16'hBEEF.
REQ-036 Address change: addr changes from 17'h0400 to 17'h0401 while ok=1 -> ok=0 in the same cycle and a new sdram_cs with sdram_addr=17'h0401.
REQ-037 Abort: vram_dma_clr in the same cycle as sdram_ok -> data is discarded, vram_dma_ok stays 0 and valid is cleared.
REQ-038 Drain: busreq=0 with a read pending -> busack stays 1 until sdram_ok, then busack=0 and cpu_bgackn=1 on the next cycle.
REQ-039 Cache (JTCPS1_VRAMCACHE_EN only): re-read addr 17'h0400 after a fill -> vram_dma_ok after 1 cycle with sdram_cs never asserted.

Source files
------------

// File: rtl/jtcps1_pkg.sv
// Shared definitions for the CPS1 VRAM bus arbiter: FSM encoding, grant
// delay default and cache geometry.
package jtcps1_pkg;
  localparam int ASN_WAIT_DEF = 2;
  localparam int CACHE_IDX_W  = 2;
  localparam int CACHE_TAG_W  = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAITAS = 3'd2,
    ST_OWN    = 3'd3,
    ST_DRAIN  = 3'd4
  } arb_st_t;
endpackage

// File: rtl/jtcps1_vram_cache.sv
// Direct-mapped VRAM word cache, indexed by addr[2:1]; combinational lookup,
// written on every SDRAM fill, flushed by i_inv.
module jtcps1_vram_cache import jtcps1_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inv,
  input  logic        i_we,
  input  logic [17:1] i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [17:1] i_raddr,
  output logic        o_hit,
  output logic [15:0] o_rdata
);
  localparam int N = 2**CACHE_IDX_W;

  logic [N-1:0]                  r_val;
  logic [N-1:0][CACHE_TAG_W-1:0] r_tag;
  logic [N-1:0][15:0]            r_dat;
  logic [CACHE_IDX_W-1:0]        w_ridx, w_widx;

  assign w_ridx  = i_raddr[2:1];
  assign w_widx  = i_waddr[2:1];
  assign o_hit   = r_val[w_ridx] && (r_tag[w_ridx] == i_raddr[17:3]);
  assign o_rdata = r_dat[w_ridx];

  // Tags and data need no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (rst || i_inv) begin
      r_val <= '0;
    end else if (i_we) begin
      r_val[w_widx] <= 1'b1;
      r_tag[w_widx] <= i_waddr[17:3];
      r_dat[w_widx] <= i_wdata;
    end
  end
endmodule

// File: rtl/jtcps1_vram_arb.sv
// Takes the 68000 bus (BR/BG/BGACK) on behalf of the video DMA and serves its
// word reads from SDRAM. JTCPS1_VRAMCACHE_EN adds a 4-entry read cache.
module jtcps1_vram_arb import jtcps1_pkg::*; #(
  parameter int ASN_WAIT = ASN_WAIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busreq,
  output logic        busack,
  input  logic [17:1] vram_dma_addr,
  input  logic        vram_dma_cs,
  input  logic        vram_dma_clr,
  output logic [15:0] vram_dma_data,
  output logic        vram_dma_ok,
  input  logic        cpu_asn,
  output logic        cpu_brn,
  input  logic        cpu_bgn,
  output logic        cpu_bgackn,
  output logic [17:1] sdram_addr,
  output logic        sdram_cs,
  input  logic [15:0] sdram_data,
  input  logic        sdram_ok
);
  localparam int CW = $clog2(ASN_WAIT + 2);
  localparam logic [CW-1:0] ASN_MAX = CW'(ASN_WAIT);

  arb_st_t     r_st, w_st_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic        r_scs, r_vld;
  logic [17:1] r_saddr, r_vaddr;
  logic [15:0] r_data;
  logic        w_own, w_hit, w_issue, w_fill, w_cload, w_chit;
  logic [15:0] w_cdata;

  assign w_own   = (r_st == ST_OWN);
  assign w_hit   = r_vld && (r_vaddr == vram_dma_addr);
  assign w_fill  = w_own && r_scs && sdram_ok && !vram_dma_clr;
  assign w_cload = w_own && busreq && vram_dma_cs && !vram_dma_clr && !w_hit && w_chit;
  assign w_issue = w_own && busreq && vram_dma_cs && !vram_dma_clr && !w_hit && !w_chit && !r_scs;

  assign busack        = (r_st == ST_OWN) || (r_st == ST_DRAIN);
  assign cpu_bgackn    = !busack;
  assign cpu_brn       = !((r_st == ST_REQ) || (r_st == ST_WAITAS));
  assign sdram_cs      = r_scs;
  assign sdram_addr    = r_saddr;
  assign vram_dma_ok   = w_own && vram_dma_cs && w_hit;
  assign vram_dma_data = r_data;

`ifdef JTCPS1_VRAMCACHE_EN
  logic w_inv;
  assign w_inv = !w_own || vram_dma_clr;

  jtcps1_vram_cache u_cache (
    .clk     (clk),
    .rst     (rst),
    .i_inv   (w_inv),
    .i_we    (w_fill),
    .i_waddr (r_saddr),
    .i_wdata (sdram_data),
    .i_raddr (vram_dma_addr),
    .o_hit   (w_chit),
    .o_rdata (w_cdata)
  );
`else
  assign w_chit  = 1'b0;
  assign w_cdata = '0;
`endif

  // The cycle that sees BG low also counts toward ASN_WAIT, so the grant
  // lands ASN_WAIT cycles after BG is first seen low with AS idle.
  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = '0;
    if ((r_st == ST_REQ || r_st == ST_WAITAS) && cpu_asn && !cpu_bgn)
      w_cnt_nxt = (r_cnt == ASN_MAX) ? r_cnt : r_cnt + 1'b1;
    case (r_st)
      ST_IDLE:   if (busreq) w_st_nxt = ST_REQ;
      ST_REQ:    if (!busreq) w_st_nxt = ST_IDLE;
                 else if (!cpu_bgn) w_st_nxt = (w_cnt_nxt == ASN_MAX) ? ST_OWN : ST_WAITAS;
      ST_WAITAS: if (!busreq) w_st_nxt = ST_IDLE;
                 else if (w_cnt_nxt == ASN_MAX) w_st_nxt = ST_OWN;
      // A read answered or aborted this very cycle is no longer pending.
      ST_OWN:    if (!busreq)
                   w_st_nxt = (r_scs && !sdram_ok && !vram_dma_clr) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:  if (sdram_ok) w_st_nxt = ST_IDLE;
      default:   w_st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= ST_IDLE;
      r_cnt   <= '0;
      r_scs   <= 1'b0;
      r_saddr <= '0;
      r_vld   <= 1'b0;
      r_vaddr <= '0;
      r_data  <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_issue) begin
        r_scs   <= 1'b1;
        r_saddr <= vram_dma_addr;
      end else if (sdram_ok || (w_own && vram_dma_clr)) begin
        r_scs <= 1'b0;
      end
      if (!w_own || vram_dma_clr) begin
        r_vld <= 1'b0;
      end else if (w_fill) begin
        r_vld   <= 1'b1;
        r_vaddr <= r_saddr;
        r_data  <= sdram_data;
      end else if (w_cload) begin
        r_vld   <= 1'b1;
        r_vaddr <= vram_dma_addr;
        r_data  <= w_cdata;
      end
    end
  end
endmodule
